// File: rtl/apu_arb_package.sv
// rtl/apu_arb_package.sv - shared defaults and core ID type for the APU arbiter
package apu_arb_package;

    localparam int NB_CORES_DEF        = 8;
    localparam int WOP_DEF             = 7;
    localparam int NARGS_DEF           = 3;
    localparam int WARG_DEF            = 32;
    localparam int NUSFLAGS_DEF        = 5;
    localparam int NDSFLAGS_DEF        = 15;
    localparam int WRESULT_DEF         = 32;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef logic [$clog2(NB_CORES_DEF)-1:0] core_id_t;

endpackage

// File: rtl/apu_arb_id_fifo.sv
// rtl/apu_arb_id_fifo.sv - in-order FIFO of issuing core IDs
module apu_arb_id_fifo
    import apu_arb_package::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF,
    parameter int WIDTH = $bits(core_id_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apu_shared_arbiter.sv
// rtl/apu_shared_arbiter.sv - round-robin sharing of one APU; optional stall counters via APU_ARB_PERF_CNT_EN
module apu_shared_arbiter
    import apu_arb_package::*;
#(
    parameter int NB_CORES        = NB_CORES_DEF,
    parameter int NARGS           = NARGS_DEF,
    parameter int WARG            = WARG_DEF,
    parameter int WOP             = WOP_DEF,
    parameter int NDSFLAGS        = NDSFLAGS_DEF,
    parameter int NUSFLAGS        = NUSFLAGS_DEF,
    parameter int WRESULT         = WRESULT_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NB_CORES-1:0]             core_req_i,
    output logic [NB_CORES-1:0]             core_gnt_o,
    input  logic [NB_CORES*WOP-1:0]         core_op_i,
    input  logic [NB_CORES*NARGS*WARG-1:0]  core_operands_i,
    input  logic [NB_CORES*NDSFLAGS-1:0]    core_flags_i,
    output logic [NB_CORES-1:0]             core_rvalid_o,
    output logic [WRESULT-1:0]              core_result_o,
    output logic [NUSFLAGS-1:0]             core_rflags_o,
    output logic                            unit_req_o,
    input  logic                            unit_gnt_i,
    output logic [WOP-1:0]                  unit_op_o,
    output logic [NARGS*WARG-1:0]           unit_operands_o,
    output logic [NDSFLAGS-1:0]             unit_flags_o,
    input  logic                            unit_rvalid_i,
    input  logic [WRESULT-1:0]              unit_result_i,
    input  logic [NUSFLAGS-1:0]             unit_rflags_i,
    output logic                            err_o,
    input  logic                            perf_clr_i,
    output logic [NB_CORES*32-1:0]          perf_stall_o
);

    localparam int IDW = $clog2(NB_CORES);
    localparam int OPW = NARGS * WARG;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] lo_idx;
    logic [IDW-1:0] hi_idx;
    logic           lo_v;
    logic           hi_v;
    logic           xfer;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [IDW-1:0] head_id;

    // Lowest requester at/above the pointer wins, else lowest overall (wrap)
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        lo_v   = 1'b0;
        hi_v   = 1'b0;
        for (int c = NB_CORES - 1; c >= 0; c--) begin
            if (core_req_i[c]) begin
                lo_idx = IDW'(c);
                lo_v   = 1'b1;
                if (IDW'(c) >= rr_ptr) begin
                    hi_idx = IDW'(c);
                    hi_v   = 1'b1;
                end
            end
        end
    end

    assign winner     = hi_v ? hi_idx : lo_idx;
    assign unit_req_o = lo_v && !fifo_full;
    assign xfer       = unit_req_o && unit_gnt_i;
    assign pop        = unit_rvalid_i && !fifo_empty;

    // Forward the winner's op fields and grant; all zero with no requester
    always_comb begin
        unit_op_o       = '0;
        unit_operands_o = '0;
        unit_flags_o    = '0;
        core_gnt_o      = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            if (lo_v && winner == IDW'(c)) begin
                unit_op_o       = core_op_i[c*WOP +: WOP];
                unit_operands_o = core_operands_i[c*OPW +: OPW];
                unit_flags_o    = core_flags_i[c*NDSFLAGS +: NDSFLAGS];
                core_gnt_o[c]   = xfer;
            end
        end
    end

    // Pointer moves past the core just served, only on a real transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (winner == IDW'(NB_CORES - 1)) ? '0 : winner + IDW'(1);
        end
    end

    apu_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (xfer),
        .wdata (winner),
        .pop   (pop),
        .rdata (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Registered return: steer result to the head-of-FIFO core, flag orphans
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_rvalid_o <= '0;
            core_result_o <= '0;
            core_rflags_o <= '0;
            err_o         <= 1'b0;
        end else begin
            for (int c = 0; c < NB_CORES; c++) begin
                core_rvalid_o[c] <= pop && (head_id == IDW'(c));
            end
            if (pop) begin
                core_result_o <= unit_result_i;
                core_rflags_o <= unit_rflags_i;
            end
            if (unit_rvalid_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef APU_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt [NB_CORES];

    // Saturating count of cycles each core waits with a pending request
    always_ff @(posedge clk) begin
        for (int c = 0; c < NB_CORES; c++) begin
            if (!rst_n || perf_clr_i) begin
                stall_cnt[c] <= '0;
            end else if (core_req_i[c] && !core_gnt_o[c] && stall_cnt[c] != '1) begin
                stall_cnt[c] <= stall_cnt[c] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NB_CORES; g++) begin : g_perf
        assign perf_stall_o[g*32 +: 32] = stall_cnt[g];
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr_i;
    assign perf_stall_o    = '0;
`endif

endmodule

// File: tb/tb_apu_shared_arbiter.sv
// tb/tb_apu_shared_arbiter.sv - self-checking bench for apu_shared_arbiter
module tb_apu_shared_arbiter;

    localparam int NB  = 8;
    localparam int MAXO = 4;

    logic           clk;
    logic           rst_n;
    logic [7:0]     core_req_i;
    logic [7:0]     core_gnt_o;
    logic [55:0]    core_op_i;
    logic [767:0]   core_operands_i;
    logic [119:0]   core_flags_i;
    logic [7:0]     core_rvalid_o;
    logic [31:0]    core_result_o;
    logic [4:0]     core_rflags_o;
    logic           unit_req_o;
    logic           unit_gnt_i;
    logic [6:0]     unit_op_o;
    logic [95:0]    unit_operands_o;
    logic [14:0]    unit_flags_o;
    logic           unit_rvalid_i;
    logic [31:0]    unit_result_i;
    logic [4:0]     unit_rflags_i;
    logic           err_o;
    logic           perf_clr_i;
    logic [255:0]   perf_stall_o;

    apu_shared_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_req_i      (core_req_i),
        .core_gnt_o      (core_gnt_o),
        .core_op_i       (core_op_i),
        .core_operands_i (core_operands_i),
        .core_flags_i    (core_flags_i),
        .core_rvalid_o   (core_rvalid_o),
        .core_result_o   (core_result_o),
        .core_rflags_o   (core_rflags_o),
        .unit_req_o      (unit_req_o),
        .unit_gnt_i      (unit_gnt_i),
        .unit_op_o       (unit_op_o),
        .unit_operands_o (unit_operands_o),
        .unit_flags_o    (unit_flags_o),
        .unit_rvalid_i   (unit_rvalid_i),
        .unit_result_i   (unit_result_i),
        .unit_rflags_i   (unit_rflags_i),
        .err_o           (err_o),
        .perf_clr_i      (perf_clr_i),
        .perf_stall_o    (perf_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-core op fields
    logic [6:0]  op_a  [NB];
    logic [95:0] opd_a [NB];
    logic [14:0] flg_a [NB];

    // reference model state
    int          rr;
    int          q[$];
    logic [7:0]  e_rv;
    logic [31:0] e_res;
    logic [4:0]  e_rfl;
    logic        e_err;
    logic [31:0] e_stall [NB];

    // last-cycle observations for directed checks
    logic [7:0]  obs_gnt;
    logic        obs_ureq;
    logic [7:0]  obs_rv;
    bit          last_xfer;
    int          last_w;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NB; i++) begin
            core_op_i[i*7 +: 7]        = op_a[i];
            core_operands_i[i*96 +: 96] = opd_a[i];
            core_flags_i[i*15 +: 15]   = flg_a[i];
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NB; i++) begin
            op_a[i]  = 7'($urandom);
            opd_a[i] = {$urandom, $urandom, $urandom};
            flg_a[i] = 15'($urandom);
        end
    endtask

    function automatic logic [255:0] exp_perf();
        logic [255:0] v;
        for (int i = 0; i < NB; i++) v[i*32 +: 32] = e_stall[i];
        return v;
    endfunction

    task automatic model_reset();
        rr    = 0;
        q.delete();
        e_rv  = '0;
        e_res = '0;
        e_rfl = '0;
        e_err = 1'b0;
        for (int i = 0; i < NB; i++) e_stall[i] = '0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        core_req_i    = '0;
        unit_gnt_i    = 1'b0;
        unit_rvalid_i = 1'b0;
        perf_clr_i    = 1'b0;
        pack();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_rvalid", core_rvalid_o, e_rv);
        chk("rst_result", core_result_o, e_res);
        chk("rst_rflags", core_rflags_o, e_rfl);
        chk("rst_err",    err_o, 1'b0);
        chk("rst_ureq",   unit_req_o, 1'b0);
        chk("rst_gnt",    core_gnt_o, 8'h00);
        chk("rst_perf",   perf_stall_o, 256'h0);
        rst_n = 1'b1;
    endtask

    // One clock: check issue path now, advance the model, check return path after the edge
    task automatic cycle();
        int   w;
        int   c;
        bit   eur;
        bit   xfer;
        bit   popv;
        int   id;
        logic [7:0] eg;
        pack();
        #1;
        w = -1;
        for (int k = 0; k < NB; k++) begin
            c = (rr + k) % NB;
            if (w < 0 && ((core_req_i >> c) & 8'h01) != 8'h00) w = c;
        end
        eur  = (w >= 0) && (q.size() < MAXO);
        xfer = eur && unit_gnt_i;
        eg   = xfer ? 8'(1 << w) : 8'h00;
        obs_ureq = unit_req_o;
        obs_gnt  = core_gnt_o;
        chk("unit_req", unit_req_o, eur);
        chk("core_gnt", core_gnt_o, eg);
        chk("unit_op",  unit_op_o,       (w < 0) ? 7'h0  : op_a[w]);
        chk("unit_opd", unit_operands_o, (w < 0) ? 96'h0 : opd_a[w]);
        chk("unit_flg", unit_flags_o,    (w < 0) ? 15'h0 : flg_a[w]);

        popv = unit_rvalid_i && (q.size() > 0);
        if (popv) begin
            id    = q.pop_front();
            e_rv  = 8'(1 << id);
            e_res = unit_result_i;
            e_rfl = unit_rflags_i;
        end else begin
            e_rv = 8'h00;
        end
        if (unit_rvalid_i && !popv) e_err = 1'b1;
        if (xfer) begin
            q.push_back(w);
            rr = (w + 1) % NB;
        end
`ifdef APU_ARB_PERF_CNT_EN
        for (int i = 0; i < NB; i++) begin
            if (perf_clr_i) e_stall[i] = '0;
            else if (((core_req_i >> i) & 8'h01) != 8'h00 && ((eg >> i) & 8'h01) == 8'h00
                     && e_stall[i] != 32'hFFFF_FFFF)
                e_stall[i] = e_stall[i] + 32'd1;
        end
`endif
        last_xfer = xfer;
        last_w    = w;

        @(posedge clk);
        #1;
        obs_rv = core_rvalid_o;
        chk("rvalid", core_rvalid_o, e_rv);
        chk("result", core_result_o, e_res);
        chk("rflags", core_rflags_o, e_rfl);
        chk("err",    err_o, e_err);
        chk("perf",   perf_stall_o, exp_perf());
    endtask

    initial begin
        int grants[$];
        bit sched [0:63];
        rst_n = 1'b0;
        core_req_i = '0; unit_gnt_i = 1'b0; unit_rvalid_i = 1'b0;
        unit_result_i = '0; unit_rflags_i = '0; perf_clr_i = 1'b0;
        rand_fields();
        pack();
        do_reset();

        // single request from core 2, result back one cycle later
        op_a[2] = 7'h05;
        core_req_i = 8'h04; unit_gnt_i = 1'b1;
        cycle();
        chk("t1_gnt", obs_gnt, 8'h04);
        core_req_i = 8'h00; unit_rvalid_i = 1'b1;
        unit_result_i = 32'hDEADBEEF; unit_rflags_i = 5'h0A;
        cycle();
        chk("t1_rvalid", obs_rv, 8'h04);
        chk("t1_result", core_result_o, 32'hDEADBEEF);
        unit_rvalid_i = 1'b0;
        cycle();

        // all cores requesting, results returned 3 cycles after issue
        do_reset();
        for (int n = 0; n < 64; n++) sched[n] = 1'b0;
        core_req_i = 8'hFF; unit_gnt_i = 1'b1;
        for (int n = 0; n < 30; n++) begin
            rand_fields();
            unit_rvalid_i = sched[n];
            unit_result_i = $urandom;
            unit_rflags_i = 5'($urandom);
            cycle();
            if (last_xfer) begin
                grants.push_back(last_w);
                if (n + 3 < 64) sched[n + 3] = 1'b1;
            end
        end
        for (int k = 0; k < 9; k++) chk("t2_order", grants[k], k % NB);

        // no results: fill to MAX_OUTSTANDING, then one pop releases issue a cycle later
        do_reset();
        core_req_i = 8'hFF; unit_gnt_i = 1'b1; unit_rvalid_i = 1'b0;
        for (int n = 0; n < 4; n++) cycle();
        cycle();
        chk("t3_full_ureq", obs_ureq, 1'b0);
        chk("t3_full_gnt",  obs_gnt, 8'h00);
        unit_rvalid_i = 1'b1; unit_result_i = 32'h1234_5678;
        cycle();
        chk("t3_pop_ureq", obs_ureq, 1'b0);
        chk("t3_pop_rv",   obs_rv, 8'h01);
        unit_rvalid_i = 1'b0;
        cycle();
        chk("t3_resume_gnt", obs_gnt, 8'h10);

        // reset with ops outstanding, then an orphan result
        do_reset();
        core_req_i = 8'h00; unit_rvalid_i = 1'b1;
        cycle();
        chk("t5_err", err_o, 1'b1);
        chk("t5_rv",  obs_rv, 8'h00);
        unit_rvalid_i = 1'b0;
        cycle();
        chk("t5_err_sticky", err_o, 1'b1);
        do_reset();

        // push and pop together at count 2
        core_req_i = 8'h01; unit_gnt_i = 1'b1;
        cycle();
        core_req_i = 8'h02;
        cycle();
        core_req_i = 8'h20; unit_rvalid_i = 1'b1; unit_result_i = 32'hCAFE_F00D;
        cycle();
        chk("t4_gnt", obs_gnt, 8'h20);
        chk("t4_rv",  obs_rv, 8'h01);
        unit_rvalid_i = 1'b0; core_req_i = 8'hFF;
        cycle();
        cycle();
        cycle();
        chk("t4_full", obs_ureq, 1'b0);

        // core 1 blocked for 5 cycles, then clear
        do_reset();
        core_req_i = 8'h02; unit_gnt_i = 1'b0;
        repeat (5) cycle();
`ifdef APU_ARB_PERF_CNT_EN
        chk("t6_stall", perf_stall_o[63:32], 32'd5);
`else
        chk("t6_stall", perf_stall_o[63:32], 32'd0);
`endif
        perf_clr_i = 1'b1;
        cycle();
        perf_clr_i = 1'b0;
        chk("t6_clr", perf_stall_o[63:32], 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_fields();
            core_req_i    = 8'($urandom);
            unit_gnt_i    = ($urandom % 4) != 0;
            unit_rvalid_i = ($urandom % 3) == 0;
            unit_result_i = $urandom;
            unit_rflags_i = 5'($urandom);
            perf_clr_i    = ($urandom % 25) == 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apu_shared_arbiter.md
Name: apu_shared_arbiter

Overview:
- Shares one APU (shared FPU / DSP-mult cluster resource) between NB_CORES cores.
- Round-robin arbitration of core requests onto a single req/gnt issue port.
- Tracks the issuing core of every in-flight op in an in-order ID FIFO, and routes each unit result back to that core.
- Sits in the cluster between the core APU interfaces and the shared unit.

Parameters:
- NB_CORES, 8, number of requesting cores (>=2).
- NARGS, 3, operands per op.
- WARG, 32, operand width.
- WOP, 7, opcode width.
- NDSFLAGS, 15, downstream (core->unit) flag width.
- NUSFLAGS, 5, upstream (unit->core) flag width.
- WRESULT, 32, result width.
- MAX_OUTSTANDING, 4, ID FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  cluster clock.
- rst_n  in  1  synchronous active-low reset.
- core_req_i  in  NB_CORES  per-core request.
- core_gnt_o  out  NB_CORES  per-core grant, one-hot or zero.
- core_op_i  in  NB_CORES*WOP  per-core opcode.
- core_operands_i  in  NB_CORES*NARGS*WARG  per-core operands.
- core_flags_i  in  NB_CORES*NDSFLAGS  per-core flags.
- core_rvalid_o  out  NB_CORES  per-core result valid, one-hot or zero.
- core_result_o  out  WRESULT  result, broadcast to all cores.
- core_rflags_o  out  NUSFLAGS  result flags, broadcast to all cores.
- unit_req_o  out  1  issue request to unit.
- unit_gnt_i  in  1  unit accepts the op.
- unit_op_o  out  WOP  muxed opcode.
- unit_operands_o  out  NARGS*WARG  muxed operands.
- unit_flags_o  out  NDSFLAGS  muxed flags.
- unit_rvalid_i  in  1  result valid; results return in issue order.
- unit_result_i  in  WRESULT  unit result.
- unit_rflags_i  in  NUSFLAGS  unit result flags.
- err_o  out  1  sticky protocol error.
- perf_clr_i  in  1  clear the perf counters.
- perf_stall_o  out  NB_CORES*32  per-core stall counters.

Behaviour:
- Reset: synchronous, active-low; clk and rst_n only, no async path.
  - On reset: RR pointer=0, FIFO empty, core_rvalid_o=0, core_result_o=0, core_rflags_o=0, err_o=0, counters=0.
  - Reset mid-operation drops all outstanding IDs; later unit_rvalid_i with an empty FIFO sets err_o.
- Issue path (combinational, same cycle):
  - winner = first core with core_req_i set, searching from the RR pointer upward with wrap.
  - unit_req_o = |core_req_i & ~full.
  - unit_op/operands/flags = winner's fields; all zero when there is no request.
  - core_gnt_o[winner] = unit_gnt_i & unit_req_o.
- Transfer = unit_req_o & unit_gnt_i. On a transfer:
  - push winner ID into the FIFO;
  - RR pointer <= winner+1 mod NB_CORES.
  - No transfer leaves the pointer unchanged.
- Full: issue is blocked while FIFO count==MAX_OUTSTANDING, even if a pop occurs in the same cycle (no bypass).
- Return path (registered, 1-cycle latency):
  - On unit_rvalid_i with FIFO non-empty: pop head ID.
  - Next cycle: core_rvalid_o[ID]=1, core_result_o/core_rflags_o = the captured values.
  - core_rvalid_o is 0 in every other cycle; result/flags hold their last value.
- Simultaneous push and pop in one cycle: both happen, count unchanged.
- unit_rvalid_i with empty FIFO: no pop, no core_rvalid_o, err_o<=1 (sticky until reset).
- ID width = $clog2(NB_CORES); FIFO pointers wrap mod MAX_OUTSTANDING; count width = $clog2(MAX_OUTSTANDING)+1.

Optional Feature:
- APU_ARB_PERF_CNT_EN defined:
  - perf_stall_o[i] increments, saturating at 2^32-1, each cycle core_req_i[i] & ~core_gnt_o[i].
  - perf_clr_i=1 zeroes all counters (clear wins over increment).
- Not defined: no counter flops; perf_stall_o tied to 0; perf_clr_i ignored.
- Ports exist in both builds.

Decomposition:
- Package apu_arb_package holds:
  - default constants NB_CORES_DEF, WOP_DEF=7, NARGS_DEF=3, NUSFLAGS_DEF=5, NDSFLAGS_DEF=15;
  - typedef for the core ID (logic [$clog2(NB_CORES)-1:0]).
- One sub-module, apu_arb_id_fifo: sync FIFO of core IDs with push/pop/full/empty, same clk/rst_n.

Test Plan:
- Single core 2 requests op=7'h05 with unit_gnt_i=1; unit_rvalid_i one cycle later with result 32'hDEADBEEF -> core_gnt_o=8'h04 in the issue cycle; core_rvalid_o=8'h04 and core_result_o=32'hDEADBEEF one cycle after unit_rvalid_i.
- All 8 cores request continuously, unit_gnt_i=1, results returned 3 cycles after issue -> grants in order 0,1,...,7,0; each core's rvalid follows its own issue order.
- unit_gnt_i=1, no results returned -> after 4 grants unit_req_o=0 and core_gnt_o=0; one unit_rvalid_i -> issue resumes the cycle after the pop, not the same cycle.
- Push and pop in the same cycle with count=2 -> count stays 2; returned ID matches the FIFO head.
- unit_rvalid_i asserted with no outstanding ops -> err_o=1 the next cycle and stays 1; core_rvalid_o stays 0; reset clears err_o.
- APU_ARB_PERF_CNT_EN defined, core 1 requesting and blocked 5 cycles -> perf_stall_o[63:32]=5; perf_clr_i pulse -> 0.
